hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core. It sits beside the decode stage and keeps its own shadow copy of the E/M/W stage occupancy: valid bit, source and destination registers, and a load flag. From that state it generates the stall, bubble and freeze controls, and the forwarding selects for the D-stage branch comparator and the E-stage ALU operands. It also counts stall cycles for performance measurement.

---
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage MIPS pipeline: keeps a shadow copy of E/M/W
// occupancy and derives stall/bubble/freeze controls, forwarding selects and a stall counter.
module hazard_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        validD,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic        useRsD,
  input  logic        useRtD,
  input  logic [4:0]  dstD,
  input  logic        loadD,
  input  logic        branchD,
  input  logic        imem_busy,
  input  logic        dmem_busy,
  output logic        stallF,
  output logic        stallD,
  output logic        flushD,
  output logic        bubbleE,
  output logic        freeze,
  output logic [1:0]  fwdA_D,
  output logic [1:0]  fwdB_D,
  output logic [1:0]  fwdA_E,
  output logic [1:0]  fwdB_E,
  output logic [31:0] stall_cnt
);

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       ld;
  } stage_t;

  localparam stage_t STAGE_EMPTY = '{v: 1'b0, rs: 5'd0, rt: 5'd0, dst: 5'd0, ld: 1'b0};

  stage_t      e_q, e_d;
  stage_t      m_q, m_d;
  stage_t      w_q, w_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic e_uses_s;
  logic m_uses_s;
  logic luse_s;
  logic bhaz_s;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  function automatic logic writes_reg(input stage_t s, input logic [4:0] r);
    return s.v && (s.dst == r) && (r != 5'd0);
  endfunction

  // A load sitting in M has no result yet, so only ALU producers forward from M.
  function automatic logic [1:0] fwd_sel(input stage_t m, input stage_t w, input logic [4:0] r);
    logic [1:0] sel;
    if (writes_reg(m, r) && !m.ld) begin
      sel = 2'b01;
    end else if (writes_reg(w, r)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Dependency detection for the instruction currently in D.
  always_comb begin
    e_uses_s = (useRsD && writes_reg(e_q, rsD)) || (useRtD && writes_reg(e_q, rtD));
    m_uses_s = (useRsD && writes_reg(m_q, rsD)) || (useRtD && writes_reg(m_q, rtD));
    luse_s   = validD && e_q.ld && e_uses_s;
    bhaz_s   = validD && branchD && (e_uses_s || (m_q.ld && m_uses_s));
  end

  // Pipeline control, highest priority first: memory wait, data hazard, fetch wait.
  always_comb begin
    stallF  = 1'b0;
    stallD  = 1'b0;
    flushD  = 1'b0;
    bubbleE = 1'b0;
    freeze  = 1'b0;
    if (dmem_busy) begin
      freeze = 1'b1;
      stallF = 1'b1;
      stallD = 1'b1;
    end else if (luse_s || bhaz_s) begin
      stallF  = 1'b1;
      stallD  = 1'b1;
      bubbleE = 1'b1;
    end else if (imem_busy) begin
      stallF = 1'b1;
      flushD = 1'b1;
    end else begin
      stallF = 1'b0;
    end
  end

  // Forwarding selects for the D-stage comparator and the E-stage ALU.
  always_comb begin
    fwdA_D = fwd_sel(m_q, w_q, rsD);
    fwdB_D = fwd_sel(m_q, w_q, rtD);
    fwdA_E = fwd_sel(m_q, w_q, e_q.rs);
    fwdB_E = fwd_sel(m_q, w_q, e_q.rt);
  end

  // Shadow pipeline advance and stall counting.
  always_comb begin
    e_d         = e_q;
    m_d         = m_q;
    w_d         = w_q;
    stall_cnt_d = stall_cnt_q;
    if (!freeze) begin
      w_d      = m_q;
      m_d      = e_q;
      e_d.v    = validD && !bubbleE;
      e_d.rs   = rsD;
      e_d.rt   = rtD;
      e_d.dst  = dstD;
      e_d.ld   = loadD;
    end else begin
      e_d = e_q;
    end
    if (stallD) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_q         <= STAGE_EMPTY;
      m_q         <= STAGE_EMPTY;
      w_q         <= STAGE_EMPTY;
      stall_cnt_q <= 32'd0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      w_q         <= w_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; control outputs are compared as
// the 5-bit vector {stallF, stallD, flushD, bubbleE, freeze}.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        validD;
  logic [4:0]  rsD, rtD, dstD;
  logic        useRsD, useRtD, loadD, branchD;
  logic        imem_busy, dmem_busy;
  logic        stallF, stallD, flushD, bubbleE, freeze;
  logic [1:0]  fwdA_D, fwdB_D, fwdA_E, fwdB_E;
  logic [31:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  localparam logic [4:0] CTL_NONE  = 5'b00000;
  localparam logic [4:0] CTL_HAZ   = 5'b11010;
  localparam logic [4:0] CTL_FRZ   = 5'b11001;
  localparam logic [4:0] CTL_IMEM  = 5'b10100;

  hazard_ctrl dut (
    .clk(clk), .resetn(resetn), .validD(validD), .rsD(rsD), .rtD(rtD),
    .useRsD(useRsD), .useRtD(useRtD), .dstD(dstD), .loadD(loadD), .branchD(branchD),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .bubbleE(bubbleE), .freeze(freeze),
    .fwdA_D(fwdA_D), .fwdB_D(fwdB_D), .fwdA_E(fwdA_E), .fwdB_E(fwdB_E),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, stallF, stallD, flushD, bubbleE, freeze}, {27'd0, exp});
  endtask

  task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic [4:0] dst,
                     input logic ld, input logic br);
    validD = v; rsD = rs; rtD = rt; useRsD = urs; useRtD = urt;
    dstD = dst; loadD = ld; branchD = br;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    imem_busy = 1'b0;
    dmem_busy = 1'b0;
    resetn    = 1'b0;
    // Reset with a live LW driven into D
    drv(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0);
    chk_ctl("reset_ctl", CTL_NONE);
    chk("reset_fwd", {24'd0, fwdA_D, fwdB_D, fwdA_E, fwdB_E}, 32'd0);
    chk("reset_cnt", stall_cnt, 32'd0);
    tick();
    chk("reset_cnt_held", stall_cnt, 32'd0);
    resetn = 1'b1;
    tick();

    // Three independent instructions
    drv(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
    chk_ctl("indep_1", CTL_NONE);
    tick();
    drv(1'b1, 5'd12, 5'd13, 1'b1, 1'b1, 5'd11, 1'b0, 1'b0);
    chk_ctl("indep_2", CTL_NONE);
    tick();
    drv(1'b1, 5'd15, 5'd16, 1'b1, 1'b1, 5'd14, 1'b0, 1'b0);
    chk_ctl("indep_3", CTL_NONE);
    tick();
    chk("indep_cnt", stall_cnt, 32'd0);
    nops(3);

    // Load-use: LW $2 ; ADDU $3,$2,$4
    drv(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0);
    chk_ctl("lu_lw", CTL_NONE);
    tick();
    drv(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    chk_ctl("lu_stall", CTL_HAZ);
    tick();
    drv(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    chk_ctl("lu_release", CTL_NONE);
    chk("lu_fwdA_D_ld_in_m", {30'd0, fwdA_D}, 32'd0);
    tick();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("lu_fwdA_E", {30'd0, fwdA_E}, 32'd2);
    chk("lu_fwdB_E", {30'd0, fwdB_E}, 32'd0);
    chk("lu_cnt", stall_cnt, 32'd1);
    tick();
    nops(3);

    // ALU back-to-back: ADDU $5 ; SUBU $6,$5,$5
    drv(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    tick();
    drv(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
    chk_ctl("alu_nostall", CTL_NONE);
    tick();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("alu_fwdA_E", {30'd0, fwdA_E}, 32'd1);
    chk("alu_fwdB_E", {30'd0, fwdB_E}, 32'd1);
    tick();
    // Write to $0, then read $0
    drv(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    tick();
    drv(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    tick();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("r0_fwd_E", {28'd0, fwdA_E, fwdB_E}, 32'd0);
    tick();
    nops(3);

    // Branch after ALU: ADDU $7 ; BEQ $7,$0
    drv(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
    tick();
    drv(1'b1, 5'd7, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
    chk_ctl("br_alu_stall", CTL_HAZ);
    tick();
    drv(1'b1, 5'd7, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
    chk_ctl("br_alu_release", CTL_NONE);
    chk("br_alu_fwdA_D", {30'd0, fwdA_D}, 32'd1);
    chk("br_alu_fwdB_D", {30'd0, fwdB_D}, 32'd0);
    tick();
    chk("br_alu_cnt", stall_cnt, 32'd2);
    nops(3);

    // Branch after load: LW $7 ; BEQ $7,$0
    drv(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    drv(1'b1, 5'd7, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
    chk_ctl("br_lw_stall1", CTL_HAZ);
    tick();
    drv(1'b1, 5'd7, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
    chk_ctl("br_lw_stall2", CTL_HAZ);
    chk("br_lw_fwdA_D_blocked", {30'd0, fwdA_D}, 32'd0);
    tick();
    drv(1'b1, 5'd7, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
    chk_ctl("br_lw_release", CTL_NONE);
    chk("br_lw_fwdA_D", {30'd0, fwdA_D}, 32'd2);
    tick();
    chk("br_lw_cnt", stall_cnt, 32'd4);
    nops(3);

    // dmem_busy for 3 cycles over a pending load-use hazard
    drv(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0);
    tick();
    dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
      chk_ctl("dmem_freeze", CTL_FRZ);
      tick();
    end
    dmem_busy = 1'b0;
    drv(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    chk_ctl("dmem_then_bubble", CTL_HAZ);
    tick();
    drv(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    chk_ctl("dmem_release", CTL_NONE);
    chk("dmem_cnt", stall_cnt, 32'd8);
    tick();
    nops(3);

    // imem_busy for 2 cycles, no hazard
    imem_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drv(1'b1, 5'd21, 5'd22, 1'b1, 1'b1, 5'd20, 1'b0, 1'b0);
      chk_ctl("imem_flush", CTL_IMEM);
      tick();
    end
    imem_busy = 1'b0;
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk_ctl("imem_release", CTL_NONE);
    chk("imem_cnt", stall_cnt, 32'd8);
    tick();
    nops(3);

    // Reset asserted in the middle of a load-use stall
    drv(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0);
    tick();
    drv(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    chk_ctl("mid_rst_pre", CTL_HAZ);
    resetn = 1'b0;
    #1;
    chk_ctl("mid_rst_ctl", CTL_NONE);
    chk("mid_rst_cnt", stall_cnt, 32'd0);
    tick();
    resetn = 1'b1;
    drv(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    chk_ctl("post_rst_ctl", CTL_NONE);
    tick();
    chk("post_rst_cnt", stall_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
